// File: rtl/mesh_job_sequencer.sv
// Job controller for the weight-stationary MAC mesh: preload, start, wait, capture.
// Define WEIGHT_REUSE_EN to add job_reuse and skip LOAD when weights are resident.
module mesh_job_sequencer #(
  parameter int DW          = 8,
  parameter int ROWS        = 8,
  parameter int COLS        = 2,
  parameter int ROW_W       = 3,
  parameter int COL_W       = 1,
  parameter int ACC_W       = 16,
  parameter int COMP_CYCLES = 10,
  parameter int CYCLE_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
`ifdef WEIGHT_REUSE_EN
  input  logic                    job_reuse,
`endif
  output logic                    job_ready,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DW-1:0]           w_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [COLS*DW-1:0]      x_data,
  output logic                    preload_valid,
  output logic [ROW_W+COL_W-1:0]  preload_addr,
  output logic [DW-1:0]           preload_data,
  output logic                    start,
  output logic [COLS*DW-1:0]      x_vector_flat,
  input  logic [ROWS*ACC_W-1:0]   result_flat,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ROWS*ACC_W-1:0]   res_data,
  output logic                    busy
);

  localparam int AW = ROW_W + COL_W;
  localparam logic [AW-1:0] LAST = AW'(ROWS * COLS - 1);
  localparam logic [CYCLE_W-1:0] WAIT_INIT = CYCLE_W'(COMP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_START, S_WAIT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wcnt_q, wcnt_d;
  logic [CYCLE_W-1:0]     ccnt_q, ccnt_d;
  logic                   pv_q, pv_d;
  logic [AW-1:0]          pa_q, pa_d;
  logic [DW-1:0]          pd_q, pd_d;
  logic [COLS*DW-1:0]     xv_q, xv_d;
  logic [ROWS*ACC_W-1:0]  rd_q, rd_d;
  logic                   reuse_hit;

`ifdef WEIGHT_REUSE_EN
  logic loaded_q, loaded_d;

  assign reuse_hit = job_reuse & loaded_q;

  // A fresh load invalidates resident weights until it completes.
  always_comb begin
    loaded_d = loaded_q;
    if (state_q == S_IDLE && job_valid && !job_reuse)
      loaded_d = 1'b0;
    if (state_q == S_LOAD && w_valid && wcnt_q == LAST)
      loaded_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) loaded_q <= 1'b0;
    else     loaded_q <= loaded_d;
  end
`else
  assign reuse_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ccnt_q  <= '0;
      pv_q    <= 1'b0;
      pa_q    <= '0;
      pd_q    <= '0;
      xv_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ccnt_q  <= ccnt_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pd_q    <= pd_d;
      xv_q    <= xv_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ccnt_d  = ccnt_q;
    pv_d    = 1'b0;
    pa_d    = pa_q;
    pd_d    = pd_q;
    xv_d    = xv_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          wcnt_d  = '0;
          state_d = reuse_hit ? S_ARM : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_valid) begin
          pv_d   = 1'b1;
          pa_d   = wcnt_q;
          pd_d   = w_data;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST) state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (x_valid) begin
          xv_d    = x_data;
          state_d = S_START;
        end
      end
      S_START: begin
        ccnt_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ccnt_q == '0) begin
          rd_d    = result_flat;
          state_d = S_DONE;
        end else begin
          ccnt_d = ccnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // job_ready is masked during reset so every output reads 0 while rst is held.
  always_comb begin
    job_ready = (state_q == S_IDLE) && !rst;
    w_ready   = (state_q == S_LOAD);
    x_ready   = (state_q == S_ARM);
    start     = (state_q == S_START);
    res_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign preload_valid = pv_q;
  assign preload_addr  = pa_q;
  assign preload_data  = pd_q;
  assign x_vector_flat = xv_q;
  assign res_data      = rd_q;

endmodule

// File: tb/tb_mesh_job_sequencer.sv
// Randomized scenario bench for mesh_job_sequencer against a cycle-log model.
// Covers reset, load stalls, backpressure, stray handshakes, mid-job reset, reuse.
module tb_mesh_job_sequencer;

  localparam int DW = 8;
  localparam int ROWS = 8;
  localparam int COLS = 2;
  localparam int ACC_W = 16;
  localparam int C = 10;
  localparam int NW = ROWS * COLS;
  localparam int RW = ROWS * ACC_W;
  localparam int XW = COLS * DW;

  logic clk = 0;
  logic rst = 1;
  logic job_valid = 0;
`ifdef WEIGHT_REUSE_EN
  logic job_reuse = 0;
`endif
  logic job_ready;
  logic w_valid = 0;
  logic w_ready;
  logic [DW-1:0] w_data = 0;
  logic x_valid = 0;
  logic x_ready;
  logic [XW-1:0] x_data = 0;
  logic preload_valid;
  logic [3:0] preload_addr;
  logic [DW-1:0] preload_data;
  logic start;
  logic [XW-1:0] x_vector_flat;
  logic [RW-1:0] result_flat = 0;
  logic res_valid;
  logic res_ready = 0;
  logic [RW-1:0] res_data;
  logic busy;

  mesh_job_sequencer dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid),
`ifdef WEIGHT_REUSE_EN
    .job_reuse(job_reuse),
`endif
    .job_ready(job_ready),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .preload_valid(preload_valid), .preload_addr(preload_addr),
    .preload_data(preload_data),
    .start(start), .x_vector_flat(x_vector_flat),
    .result_flat(result_flat),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  logic [RW-1:0] hist [0:4095];
  int pl_addr[$];
  int pl_data[$];
  int pl_cyc[$];
  int st_cyc[$];
  int rv_cyc[$];
  logic [RW-1:0] rv_dat[$];
  logic rv_prev = 0;
  int overlap_jr = 0;
  int overlap_ps = 0;

  logic [DW-1:0] wts [NW];
  logic [XW-1:0] x_model = 0;
  int x_acc_cyc = 0;

  // Mesh result changes every cycle so capture timing is observable.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < RW / 32; i++)
        result_flat[i*32 +: 32] = $urandom;
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    hist[cyc % 4096] = result_flat;
    if (preload_valid) begin
      pl_addr.push_back(int'(preload_addr));
      pl_data.push_back(int'(preload_data));
      pl_cyc.push_back(cyc);
    end
    if (start) st_cyc.push_back(cyc);
    if (res_valid && !rv_prev) begin
      rv_cyc.push_back(cyc);
      rv_dat.push_back(res_data);
    end
    rv_prev = res_valid;
    if (job_ready && res_valid) overlap_jr++;
    if (preload_valid && start) overlap_ps++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    pl_addr.delete(); pl_data.delete(); pl_cyc.delete();
    st_cyc.delete(); rv_cyc.delete(); rv_dat.delete();
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL timeout_%s: no handshake within budget", what);
  endtask

  task automatic start_job(input bit reuse);
    int n = 0;
    job_valid = 1;
`ifdef WEIGHT_REUSE_EN
    job_reuse = reuse;
`else
    if (reuse) $display("note: reuse ignored in default build");
`endif
    while (!job_ready && n < 50) begin tick; n++; end
    if (n == 50) timeout("job");
    tick;
    job_valid = 0;
  endtask

  task automatic load_weights(input bit stall);
    for (int i = 0; i < NW; i++) begin
      int n = 0;
      if (stall) begin w_valid = 0; tick; end
      w_valid = 1;
      w_data = wts[i];
      while (!w_ready && n < 50) begin tick; n++; end
      if (n == 50) timeout("w");
      tick;
      w_valid = 0;
    end
  endtask

  task automatic send_x(input logic [XW-1:0] xd);
    int n = 0;
    x_valid = 1;
    x_data = xd;
    while (!x_ready && n < 50) begin tick; n++; end
    if (n == 50) timeout("x");
    x_acc_cyc = cyc + 1;
    x_model = xd;
    tick;
    x_valid = 0;
  endtask

  task automatic collect;
    int n = 0;
    res_ready = 1;
    while (!res_valid && n < C + 20) begin tick; n++; end
    if (n == C + 20) timeout("res");
    tick;
    res_ready = 0;
  endtask

  task automatic rand_wts;
    for (int i = 0; i < NW; i++) wts[i] = DW'($urandom);
  endtask

  task automatic test_reset;
    rst = 1;
    tick; tick;
    checks++;
    if ({job_ready, w_ready, x_ready, preload_valid, preload_addr, preload_data,
         start, x_vector_flat, res_valid, res_data, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero, expected all 0");
    end
    rst = 0;
    #1;
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: job_ready=%b busy=%b expected 1 0", job_ready, busy);
    end
    tick;
  endtask

  task automatic test_basic;
    clear_log();
    for (int i = 0; i < NW; i++) wts[i] = DW'(i + 1);
    start_job(0);
    load_weights(0);
    send_x({8'd2, 8'd3});
    collect();
    checks++;
    if (pl_addr.size() != NW) begin
      errors++;
      $display("FAIL basic_strobes: got %0d expected %0d", pl_addr.size(), NW);
    end else begin
      for (int i = 0; i < NW; i++) begin
        checks++;
        if (pl_addr[i] != i || pl_data[i] != i + 1) begin
          errors++;
          $display("FAIL basic_preload[%0d]: addr %0d data %0d expected %0d %0d",
                   i, pl_addr[i], pl_data[i], i, i + 1);
        end
      end
    end
    checks++;
    if (st_cyc.size() != 1 || st_cyc[0] != x_acc_cyc + 1) begin
      errors++;
      $display("FAIL basic_start: count %0d expected 1 at cycle %0d",
               st_cyc.size(), x_acc_cyc + 1);
    end
    checks++;
    if (x_vector_flat !== 16'h0203) begin
      errors++;
      $display("FAIL basic_xvec: got %h expected 0203", x_vector_flat);
    end
    checks++;
    if (rv_cyc.size() != 1 || st_cyc.size() != 1 ||
        rv_cyc[0] - st_cyc[0] != C + 1) begin
      errors++;
      $display("FAIL basic_latency: res_valid count %0d expected 1 at start+%0d",
               rv_cyc.size(), C + 1);
    end else begin
      checks++;
      if (rv_dat[0] !== hist[(st_cyc[0] + C) % 4096]) begin
        errors++;
        $display("FAIL basic_resdata: got %h expected %h",
                 rv_dat[0], hist[(st_cyc[0] + C) % 4096]);
      end
    end
  endtask

  task automatic test_stalled_load;
    clear_log();
    rand_wts();
    start_job(0);
    load_weights(1);
    send_x(XW'($urandom));
    collect();
    checks++;
    if (pl_addr.size() != NW) begin
      errors++;
      $display("FAIL stall_strobes: got %0d expected %0d", pl_addr.size(), NW);
    end else begin
      for (int i = 0; i < NW; i++) begin
        checks++;
        if (pl_addr[i] != i || pl_data[i] != int'(wts[i])) begin
          errors++;
          $display("FAIL stall_preload[%0d]: addr %0d data %0d expected %0d %0d",
                   i, pl_addr[i], pl_data[i], i, wts[i]);
        end
      end
      checks++;
      if (st_cyc.size() != 1 || st_cyc[0] <= pl_cyc[NW-1]) begin
        errors++;
        $display("FAIL stall_start_order: starts %0d expected 1 after last strobe",
                 st_cyc.size());
      end
    end
  endtask

  task automatic test_backpressure;
    logic [RW-1:0] exp;
    int n = 0;
    clear_log();
    rand_wts();
    start_job(0);
    load_weights(0);
    send_x(XW'($urandom));
    res_ready = 0;
    while (!res_valid && n < C + 20) begin tick; n++; end
    if (n == C + 20) timeout("bp");
    exp = (st_cyc.size() == 1) ? hist[(st_cyc[0] + C) % 4096] : '0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp || job_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid %b ready %b data %h expected 1 0 %h",
                 k, res_valid, job_ready, res_data, exp);
      end
      tick;
    end
    res_ready = 1;
    tick;
    res_ready = 0;
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid %b job_ready %b expected 0 1",
               res_valid, job_ready);
    end
    checks++;
    if (overlap_jr != 0 || overlap_ps != 0) begin
      errors++;
      $display("FAIL overlaps: jr/rv %0d pl/start %0d expected 0 0",
               overlap_jr, overlap_ps);
    end
  endtask

  task automatic test_stray;
    clear_log();
    rand_wts();
    start_job(0);
    x_valid = 1;
    x_data = ~x_model;
    tick;
    x_valid = 0;
    checks++;
    if (x_vector_flat !== x_model || w_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_x: xvec %h w_ready %b expected %h 1",
               x_vector_flat, w_ready, x_model);
    end
    load_weights(0);
    w_valid = 1;
    w_data = 8'hA5;
    res_ready = 1;
    tick;
    w_valid = 0;
    res_ready = 0;
    checks++;
    if (x_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_arm: x_ready %b res_valid %b expected 1 0",
               x_ready, res_valid);
    end
    send_x(XW'($urandom));
    collect();
    checks++;
    if (pl_addr.size() != NW) begin
      errors++;
      $display("FAIL stray_strobes: got %0d expected %0d", pl_addr.size(), NW);
    end
  endtask

  task automatic test_reset_mid_wait;
    int n = 0;
    clear_log();
    rand_wts();
    start_job(0);
    load_weights(0);
    x_valid = 1;
    x_data = XW'($urandom);
    while (!start && n < 50) begin tick; n++; end
    x_valid = 0;
    if (n == 50) timeout("mid_start");
    for (int k = 0; k < C - 4; k++) tick;
    clear_log();
    rst = 1;
    tick;
    checks++;
    if ({job_ready, w_ready, x_ready, preload_valid, preload_addr, preload_data,
         start, x_vector_flat, res_valid, res_data, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got nonzero, expected all 0");
    end
    tick;
    checks++;
    if (pl_addr.size() + st_cyc.size() + rv_cyc.size() != 0) begin
      errors++;
      $display("FAIL midrst_activity: %0d events expected 0",
               pl_addr.size() + st_cyc.size() + rv_cyc.size());
    end
    rst = 0;
    x_model = '0;
    tick;
    test_basic();
  endtask

`ifdef WEIGHT_REUSE_EN
  task automatic test_reuse;
    clear_log();
    rand_wts();
    start_job(0);
    load_weights(0);
    send_x(XW'($urandom));
    collect();
    checks++;
    if (pl_addr.size() != NW) begin
      errors++;
      $display("FAIL reuse_first: strobes %0d expected %0d", pl_addr.size(), NW);
    end
    clear_log();
    start_job(1);
    checks++;
    if (x_ready !== 1'b1) begin
      errors++;
      $display("FAIL reuse_arm: x_ready %b expected 1", x_ready);
    end
    send_x(XW'($urandom));
    collect();
    checks++;
    if (pl_addr.size() != 0 || st_cyc.size() != 1 || st_cyc[0] != x_acc_cyc + 1) begin
      errors++;
      $display("FAIL reuse_skip: strobes %0d starts %0d expected 0 1",
               pl_addr.size(), st_cyc.size());
    end
    rst = 1;
    tick; tick;
    rst = 0;
    tick;
    clear_log();
    rand_wts();
    start_job(1);
    checks++;
    if (w_ready !== 1'b1) begin
      errors++;
      $display("FAIL reuse_after_reset: w_ready %b expected 1", w_ready);
    end
    load_weights(0);
    send_x(XW'($urandom));
    collect();
    checks++;
    if (pl_addr.size() != NW) begin
      errors++;
      $display("FAIL reuse_reload: strobes %0d expected %0d", pl_addr.size(), NW);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stalled_load();
    test_backpressure();
    test_stray();
    test_reset_mid_wait();
`ifdef WEIGHT_REUSE_EN
    test_reuse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
